// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three per-source result FIFOs arbitrated round-robin onto one registered common data bus
//   clk_in, rst_in        : system clock, asynchronous active-low reset
//   rdy_in                : global ready; low freezes every register and ignores pushes and _clear
//   _clear                : reorder-buffer flush; empties all queues and drops the bus valid
//   _src_valid_0/1/2      : push strobes (0 = ALU, 1 = branch/JALR, 2 = load/store)
//   _src_rob_id_0/1/2     : destination ROB entry of the pushed result
//   _src_value_0/1/2      : pushed result value
//   _src_full_0/1/2       : queue holds QDEPTH entries; further pushes are dropped
//   _cdb_ready/_rob_id/_value/_src : registered broadcast and index of the winning source
//   _busy                 : any queue non-empty or a broadcast currently on the bus
module cdb_arbiter #(
    parameter int QDEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _src_valid_0,
    input  logic        _src_valid_1,
    input  logic        _src_valid_2,
    input  logic [4:0]  _src_rob_id_0,
    input  logic [4:0]  _src_rob_id_1,
    input  logic [4:0]  _src_rob_id_2,
    input  logic [31:0] _src_value_0,
    input  logic [31:0] _src_value_1,
    input  logic [31:0] _src_value_2,
    output logic        _src_full_0,
    output logic        _src_full_1,
    output logic        _src_full_2,
    output logic        _cdb_ready,
    output logic [4:0]  _cdb_rob_id,
    output logic [31:0] _cdb_value,
    output logic [1:0]  _cdb_src,
    output logic        _busy
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(QDEPTH);

    // entry layout: {rob_id, value}
    typedef logic [36:0] entry_t;

    entry_t        mem_q [3][QDEPTH];
    logic [AW-1:0] rd_q [3], rd_d [3], wr_q [3], wr_d [3];
    logic [AW:0]   cnt_q [3], cnt_d [3];
    logic [1:0]    rr_q, rr_d;
    logic          cdb_ready_q, cdb_ready_d;
    logic [4:0]    cdb_id_q, cdb_id_d;
    logic [31:0]   cdb_val_q, cdb_val_d;
    logic [1:0]    cdb_src_q, cdb_src_d;

    logic [2:0] valid, full, nonempty, push, pop;
    entry_t     in_entry [3];
    entry_t     head;
    logic [1:0] c1, c2, win_idx;
    logic       arb_en, flush, grant;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign valid       = {_src_valid_2, _src_valid_1, _src_valid_0};
    assign in_entry[0] = {_src_rob_id_0, _src_value_0};
    assign in_entry[1] = {_src_rob_id_1, _src_value_1};
    assign in_entry[2] = {_src_rob_id_2, _src_value_2};

    // a stalled pipeline ignores _clear entirely
    assign arb_en = rdy_in && !_clear;
    assign flush  = rdy_in && _clear;

    // round-robin search order starting at rr_q
    assign c1      = inc3(rr_q);
    assign c2      = inc3(c1);
    assign win_idx = nonempty[rr_q] ? rr_q : nonempty[c1] ? c1 : c2;
    assign grant   = arb_en && (|nonempty);
    assign head    = mem_q[win_idx][rd_q[win_idx]];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            full[i]     = (cnt_q[i] == DEPTH);
            nonempty[i] = (cnt_q[i] != '0);
            push[i]     = valid[i] && !full[i] && arb_en;
            pop[i]      = grant && (win_idx == 2'(i));
            rd_d[i]     = flush ? '0 : rd_q[i] + AW'(pop[i]);
            wr_d[i]     = flush ? '0 : wr_q[i] + AW'(push[i]);
            cnt_d[i]    = flush ? '0 : cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
        end
        rr_d        = grant ? inc3(win_idx) : flush ? 2'd0 : rr_q;
        cdb_ready_d = rdy_in ? grant : cdb_ready_q;
        cdb_id_d    = grant ? head[36:32] : cdb_id_q;
        cdb_val_d   = grant ? head[31:0] : cdb_val_q;
        cdb_src_d   = grant ? win_idx : cdb_src_q;
    end

    // storage is left unreset; it is never read while its queue is empty
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < 3; i++)
            if (push[i]) mem_q[i][wr_q[i]] <= in_entry[i];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_q        <= '{default: '0};
            wr_q        <= '{default: '0};
            cnt_q       <= '{default: '0};
            rr_q        <= '0;
            cdb_ready_q <= 1'b0;
            cdb_id_q    <= '0;
            cdb_val_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            cdb_ready_q <= cdb_ready_d;
            cdb_id_q    <= cdb_id_d;
            cdb_val_q   <= cdb_val_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign _src_full_0 = full[0];
    assign _src_full_1 = full[1];
    assign _src_full_2 = full[2];
    assign _cdb_ready  = cdb_ready_q;
    assign _cdb_rob_id = cdb_id_q;
    assign _cdb_value  = cdb_val_q;
    assign _cdb_src    = cdb_src_q;
    assign _busy       = (|nonempty) || cdb_ready_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table plus hand sequences for flush, pause and async reset
module tb_cdb_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, clr = 1'b0;
    logic [2:0]  v = '0;
    logic [4:0]  id [3];
    logic [31:0] val [3];
    logic        full0, full1, full2, cdb_ready, busy;
    logic [4:0]  cdb_id;
    logic [31:0] cdb_val;
    logic [1:0]  cdb_src;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.QDEPTH(2)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), ._clear(clr),
        ._src_valid_0(v[0]), ._src_valid_1(v[1]), ._src_valid_2(v[2]),
        ._src_rob_id_0(id[0]), ._src_rob_id_1(id[1]), ._src_rob_id_2(id[2]),
        ._src_value_0(val[0]), ._src_value_1(val[1]), ._src_value_2(val[2]),
        ._src_full_0(full0), ._src_full_1(full1), ._src_full_2(full2),
        ._cdb_ready(cdb_ready), ._cdb_rob_id(cdb_id), ._cdb_value(cdb_val),
        ._cdb_src(cdb_src), ._busy(busy)
    );

    typedef struct {
        logic [2:0] v;
        logic [4:0] i0, i1, i2;
        logic       er;
        logic [4:0] eid;
        logic [1:0] es;
        logic [2:0] ef;
        logic       eb;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [31:0] vf(input logic [4:0] i);
        return {27'd0, i} * 32'h0101_0101;
    endfunction

    task automatic drive(input logic [2:0] vv, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        v = vv;
        id[0] = a;
        id[1] = b;
        id[2] = c;
        for (int k = 0; k < 3; k++) val[k] = vf(id[k]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic er, input logic [4:0] eid, input logic [31:0] ev,
                       input logic [1:0] es, input logic [2:0] ef, input logic eb);
        logic [43:0] act, exp;
        act = {cdb_ready, cdb_id, cdb_val, cdb_src, full2, full1, full0, busy};
        exp = {er, eid, ev, es, ef, eb};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got rdy=%0b id=%0d val=%08h src=%0d full=%03b busy=%0b, want rdy=%0b id=%0d val=%08h src=%0d full=%03b busy=%0b",
                     nm, cdb_ready, cdb_id, cdb_val, cdb_src, {full2, full1, full0}, busy, er, eid, ev, es, ef, eb);
        end
    endtask

    initial begin
        // {valid[2:0], id0, id1, id2} -> {ready, id, src, full[2:0], busy}
        tbl[0]  = '{3'b111, 5'd3,  5'd4,  5'd6,  1'b0, 5'd0,  2'd0, 3'b000, 1'b1};
        tbl[1]  = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 5'd3,  2'd0, 3'b000, 1'b1};
        tbl[2]  = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 5'd4,  2'd1, 3'b000, 1'b1};
        tbl[3]  = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 5'd6,  2'd2, 3'b000, 1'b1};
        tbl[4]  = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b0, 5'd6,  2'd2, 3'b000, 1'b0};
        tbl[5]  = '{3'b111, 5'd10, 5'd11, 5'd7,  1'b0, 5'd6,  2'd2, 3'b000, 1'b1};
        tbl[6]  = '{3'b111, 5'd12, 5'd13, 5'd8,  1'b1, 5'd10, 2'd0, 3'b110, 1'b1};
        tbl[7]  = '{3'b110, 5'd0,  5'd14, 5'd9,  1'b1, 5'd11, 2'd1, 3'b100, 1'b1};
        tbl[8]  = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 5'd7,  2'd2, 3'b000, 1'b1};
        tbl[9]  = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 5'd12, 2'd0, 3'b000, 1'b1};
        tbl[10] = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 5'd13, 2'd1, 3'b000, 1'b1};
        tbl[11] = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 5'd8,  2'd2, 3'b000, 1'b1};
        tbl[12] = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b0, 5'd8,  2'd2, 3'b000, 1'b0};
        tbl[13] = '{3'b010, 5'd0,  5'd15, 5'd0,  1'b0, 5'd8,  2'd2, 3'b000, 1'b1};
        tbl[14] = '{3'b100, 5'd0,  5'd0,  5'd16, 1'b1, 5'd15, 2'd1, 3'b000, 1'b1};
        tbl[15] = '{3'b001, 5'd17, 5'd0,  5'd0,  1'b1, 5'd16, 2'd2, 3'b000, 1'b1};
        tbl[16] = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b1, 5'd17, 2'd0, 3'b000, 1'b1};
        tbl[17] = '{3'b000, 5'd0,  5'd0,  5'd0,  1'b0, 5'd17, 2'd0, 3'b000, 1'b0};

        drive(3'b000, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 1'b0, 5'd0, 32'd0, 2'd0, 3'b000, 1'b0);
        #4 rst_n = 1'b1;

        for (int n = 0; n < 18; n++) begin
            drive(tbl[n].v, tbl[n].i0, tbl[n].i1, tbl[n].i2);
            step();
            chk($sformatf("vec%0d", n), tbl[n].er, tbl[n].eid, vf(tbl[n].eid), tbl[n].es, tbl[n].ef, tbl[n].eb);
        end

        drive(3'b010, 5'd0, 5'd5, 5'd0);
        val[1] = 32'h0000_1234;
        step();
        chk("single_c1", 1'b0, 5'd17, vf(5'd17), 2'd0, 3'b000, 1'b1);
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        chk("single_c2", 1'b1, 5'd5, 32'h0000_1234, 2'd1, 3'b000, 1'b1);
        step();
        chk("single_c3", 1'b0, 5'd5, 32'h0000_1234, 2'd1, 3'b000, 1'b0);

        drive(3'b111, 5'd1, 5'd2, 5'd3);
        step();
        chk("flush_fill_a", 1'b0, 5'd5, 32'h0000_1234, 2'd1, 3'b000, 1'b1);
        drive(3'b111, 5'd4, 5'd5, 5'd6);
        step();
        chk("flush_fill_b", 1'b1, 5'd3, vf(5'd3), 2'd2, 3'b011, 1'b1);
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        chk("flush_fill_c", 1'b1, 5'd1, vf(5'd1), 2'd0, 3'b010, 1'b1);
        clr = 1'b1;
        drive(3'b111, 5'd20, 5'd21, 5'd22);
        step();
        clr = 1'b0;
        chk("flush_clear", 1'b0, 5'd1, vf(5'd1), 2'd0, 3'b000, 1'b0);
        drive(3'b011, 5'd23, 5'd24, 5'd0);
        step();
        chk("flush_push", 1'b0, 5'd1, vf(5'd1), 2'd0, 3'b000, 1'b1);
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        chk("flush_rr0", 1'b1, 5'd23, vf(5'd23), 2'd0, 3'b000, 1'b1);
        step();
        chk("flush_next", 1'b1, 5'd24, vf(5'd24), 2'd1, 3'b000, 1'b1);
        step();
        chk("flush_idle", 1'b0, 5'd24, vf(5'd24), 2'd1, 3'b000, 1'b0);

        drive(3'b111, 5'd25, 5'd26, 5'd9);
        step();
        chk("pause_fill", 1'b0, 5'd24, vf(5'd24), 2'd1, 3'b000, 1'b1);
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        chk("pause_bcast", 1'b1, 5'd9, vf(5'd9), 2'd2, 3'b000, 1'b1);
        rdy = 1'b0;
        clr = 1'b1;
        drive(3'b101, 5'd27, 5'd0, 5'd28);
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("pause_hold%0d", n), 1'b1, 5'd9, vf(5'd9), 2'd2, 3'b000, 1'b1);
        end
        rdy = 1'b1;
        clr = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        chk("resume_a", 1'b1, 5'd25, vf(5'd25), 2'd0, 3'b000, 1'b1);
        step();
        chk("resume_b", 1'b1, 5'd26, vf(5'd26), 2'd1, 3'b000, 1'b1);
        step();
        chk("resume_idle", 1'b0, 5'd26, vf(5'd26), 2'd1, 3'b000, 1'b0);

        drive(3'b011, 5'd11, 5'd12, 5'd0);
        step();
        chk("areset_fill", 1'b0, 5'd26, vf(5'd26), 2'd1, 3'b000, 1'b1);
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        step();
        chk("areset_bcast", 1'b1, 5'd11, vf(5'd11), 2'd0, 3'b000, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("areset_async", 1'b0, 5'd0, 32'd0, 2'd0, 3'b000, 1'b0);
        #2 rst_n = 1'b1;
        step();
        chk("areset_post1", 1'b0, 5'd0, 32'd0, 2'd0, 3'b000, 1'b0);
        step();
        chk("areset_post2", 1'b0, 5'd0, 32'd0, 2'd0, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, per-source result queue depth; legal values are powers of two, minimum 2.
REQ-002 SHALL have port clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rdy_in  input  1  global ready; when low, all state is frozen.
REQ-005 SHALL have port _clear  input  1  pipeline flush from the reorder buffer (mispredict).
REQ-006 SHALL have ports _src_valid_0/1/2  input  1 each  result push strobe; 0 = ALU, 1 = branch/JALR unit, 2 = load/store unit.
REQ-007 SHALL have ports _src_rob_id_0/1/2  input  5 each  destination ROB entry (1..31) of the pushed result.
REQ-008 SHALL have ports _src_value_0/1/2  input  32 each  result value.
REQ-009 SHALL have ports _src_full_0/1/2  output  1 each  queue i holds QDEPTH entries; source must not push.
REQ-010 SHALL have port _cdb_ready  output  1  registered broadcast valid to the ROB and reservation stations.
REQ-011 SHALL have port _cdb_rob_id  output  5  registered broadcast ROB id.
REQ-012 SHALL have port _cdb_value  output  32  registered broadcast value.
REQ-013 SHALL have port _cdb_src  output  2  registered index of the winning source.
REQ-014 SHALL have port _busy  output  1  high when any queue is non-empty or _cdb_ready is high.

Function
REQ-015 SHALL keep one circular FIFO per source, with read/write pointers of width log2(QDEPTH) that wrap from QDEPTH-1 to 0, and a count in the range 0..QDEPTH.
REQ-016 SHALL drive _src_full_i = (count_i == QDEPTH), decoded combinationally from registered state only, with no same-cycle pop pass-through.
REQ-017 SHALL accept a push on source i when _src_valid_i && !_src_full_i && rdy_in && !_clear.
REQ-018 SHALL silently drop a push while the queue is full; the bench flags this as a protocol error.
REQ-019 SHALL arbitrate each cycle with rdy_in high and _clear low among queues non-empty at cycle start, searching from rr_ptr upward modulo 3; the first non-empty queue wins.
REQ-020 SHALL, on a win by queue w: pop its head; register _cdb_ready=1, _cdb_rob_id/_cdb_value = head entry, _cdb_src=w; set rr_ptr=(w+1) mod 3.
REQ-021 SHALL, when no queue is non-empty: register _cdb_ready=0, hold _cdb_rob_id/_cdb_value/_cdb_src, and leave rr_ptr unchanged.
REQ-022 SHALL issue at most one broadcast per cycle.
REQ-023 SHALL give minimum latency of 2 cycles: push sampled at edge N, queue visible in cycle N+1, broadcast visible in cycle N+2; there is no empty-queue bypass.
REQ-024 SHALL, on a simultaneous push and pop of the same queue, perform both, leaving the count unchanged.
REQ-025 SHALL preserve FIFO order within each source; no ordering is guaranteed across sources.
REQ-026 SHALL give fairness: with all three queues continuously non-empty, the grant sequence rotates 0,1,2,0...; each source waits at most 2 broadcasts once at its queue head.
REQ-027 SHALL, when _clear is high with rdy_in high: zero all counts and pointers, set rr_ptr=0 and _cdb_ready=0, discard same-cycle pushes, and perform no arbitration; clear has priority over push and pop.
REQ-028 SHALL, when rdy_in is low: hold all registers including output registers (a high _cdb_ready stays high), and ignore pushes and _clear.
REQ-029 SHALL accept only ROB ids 1..31; id 0 is pushed through unchanged and flagged by the bench only.

Reset
REQ-030 SHALL, on rst_in low, asynchronously set all counts, FIFO pointers, rr_ptr, _cdb_ready, _cdb_rob_id, _cdb_value and _cdb_src to 0, giving _src_full_*=0 and _busy=0.
REQ-031 SHALL, on reset assertion mid-operation, immediately discard queued entries; no broadcast occurs on the first edge after release unless a push precedes it.
REQ-032 SHALL leave FIFO storage contents unreset; they are unobservable while count is 0.

Verification
REQ-033 SHALL cover single push: src1 pushes (id 5, 0x1234) at edge 0 -> _cdb_ready=1, id 5, value 0x1234, _cdb_src=1 in cycle 2 only; _busy falls in cycle 3.
REQ-034 SHALL cover three-way contention: all sources push at edge 0 with ids 3/4/6 and rr_ptr=0 -> broadcasts in cycles 2,3,4 with ids 3,4,6 and _cdb_src 0,1,2.
REQ-035 SHALL cover fill/full: src2 pushes ids 7,8 on back-to-back edges while src0/src1 are kept busy and the grant is withheld -> _src_full_2=1; a third push is dropped; ids 7 then 8 are broadcast in order.
REQ-036 SHALL cover flush: two entries queued in each source, _clear pulsed for one cycle -> the next cycle has _cdb_ready=0, all _src_full_*=0, _busy=0, and a push in the clear cycle never appears.
REQ-037 SHALL cover pause: rdy_in held low for 3 cycles while _cdb_ready=1 with id 9 -> outputs hold id 9 and queues do not change; after rdy_in rises, arbitration resumes from the saved rr_ptr.
REQ-038 SHALL cover async reset: rst_in dropped between clock edges with entries queued -> outputs go to 0 before the next edge; after release, no broadcast occurs without a new push.
